// File: rtl/led7seg_hc595_shifter_if.sv
// Frame handshake between the display-formatting logic (master) and the
// 74HC595 serialiser (slave).
interface led7seg_hc595_shifter_if #(
  parameter int FRAME_W = 16
);
  logic [FRAME_W-1:0] dat;
  logic               vld;
  logic               rdy;
  logic               done;

  modport master (output dat, vld, input rdy, done);
  modport slave  (input dat, vld, output rdy, done);
endinterface

// File: rtl/led7seg_hc595_shifter.sv
// Serialises {segment byte, digit-select byte} frames into two chained 74HC595s.
// Optional build macro LED7SEG_ACTIVE_LOW_EN inverts the segment byte at capture.
module led7seg_hc595_shifter #(
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  led7seg_hc595_shifter_if.slave  bus,
  output logic                    sclk,
  output logic                    rclk,
  output logic                    dio
);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(FRAME_W);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               sclk_q, sclk_d;
  logic               rclk_q, rclk_d;
  logic               done_q, done_d;
  logic [FRAME_W-1:0] cap_w;
  logic               div_last;

`ifdef LED7SEG_ACTIVE_LOW_EN
  // Common-anode modules: segments lit by a low level; digit select untouched.
  assign cap_w = {~bus.dat[FRAME_W-1 -: 8], bus.dat[FRAME_W-9:0]};
`else
  assign cap_w = bus.dat;
`endif

  assign div_last = (div_cnt_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    rclk_d    = rclk_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        rclk_d = 1'b0;
        if (bus.vld) begin
          shreg_d   = cap_w;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          sclk_d    = 1'b1;
          div_cnt_d = '0;
          state_d   = SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_last) begin
          sclk_d    = 1'b0;
          div_cnt_d = '0;
          shreg_d   = shreg_q << 1;
          if (bit_cnt_q == BIT_W'(FRAME_W - 1)) begin
            rclk_d  = 1'b1;
            state_d = LATCH;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            state_d   = SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      LATCH: begin
        sclk_d = 1'b0;
        if (div_last) begin
          rclk_d    = 1'b0;
          done_d    = 1'b1;
          div_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      rclk_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      rclk_q    <= rclk_d;
      done_q    <= done_d;
    end
  end

  // The shift register MSB is the serial data flop, so dio holds between frames.
  assign dio      = shreg_q[FRAME_W-1];
  assign sclk     = sclk_q;
  assign rclk     = rclk_q;
  assign bus.done = done_q;
  assign bus.rdy  = (state_q == IDLE);
endmodule

// File: tb/tb_led7seg_hc595_shifter.sv
// Directed bench: one DUT at CLK_DIV=2, a second at CLK_DIV=1, sharing clk/rst.
module tb_led7seg_hc595_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led7seg_hc595_shifter_if #(.FRAME_W(16)) bus2 ();
  led7seg_hc595_shifter_if #(.FRAME_W(16)) bus1 ();
  wire sclk2, rclk2, dio2, sclk1, rclk1, dio1;

  led7seg_hc595_shifter #(.FRAME_W(16), .CLK_DIV(2)) u_dut (
    .clk(clk), .rst(rst), .bus(bus2.slave), .sclk(sclk2), .rclk(rclk2), .dio(dio2));
  led7seg_hc595_shifter #(.FRAME_W(16), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .sclk(sclk1), .rclk(rclk1), .dio(dio1));

  int checks = 0;
  int failures = 0;

  int          sclk2_cnt = 0, rclk2_cnt = 0, sclk1_cnt = 0, rclk1_cnt = 0;
  logic [15:0] bits2 = '0, bits1 = '0;
  logic [15:0] frames2[$];
  time         last_rise1 = 0, per_min1 = 0, per_max1 = 0;

  always @(posedge sclk2) begin
    sclk2_cnt++;
    bits2 = {bits2[14:0], dio2};
  end
  always @(posedge rclk2) begin
    rclk2_cnt++;
    frames2.push_back(bits2);
  end
  always @(posedge sclk1) begin
    if (sclk1_cnt > 0) begin
      if (per_min1 == 0 || $time - last_rise1 < per_min1) per_min1 = $time - last_rise1;
      if ($time - last_rise1 > per_max1) per_max1 = $time - last_rise1;
    end
    last_rise1 = $time;
    sclk1_cnt++;
    bits1 = {bits1[14:0], dio1};
  end
  always @(posedge rclk1) rclk1_cnt++;

  task automatic clear_mon();
    sclk2_cnt = 0; rclk2_cnt = 0; sclk1_cnt = 0; rclk1_cnt = 0;
    frames2.delete();
    per_min1 = 0; per_max1 = 0;
  endtask

  // Sends one frame to the CLK_DIV=2 instance and times it until rdy returns.
  task automatic run_frame2(input logic [15:0] data, output int lat, output int rhi,
                            output logic done_at, output logic done_after);
    lat = -1; rhi = 0; done_at = 1'b0; done_after = 1'b0;
    @(negedge clk);
    bus2.dat = data;
    bus2.vld = 1'b1;
    @(posedge clk);
    #1 bus2.vld = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk);
      #1;
      if (rclk2) rhi++;
      if (bus2.rdy) begin
        lat = i;
        done_at = bus2.done;
        break;
      end
    end
    @(posedge clk);
    #1 done_after = bus2.done;
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus2.rdy, bus2.done, sclk2, rclk2, dio2} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_state got rdy,done,sclk,rclk,dio=%b expected 10000",
               {bus2.rdy, bus2.done, sclk2, rclk2, dio2});
    end
    @(negedge clk) rst = 1'b0;
    clear_mon();
    @(negedge clk);
    bus2.dat = 16'hFFFF;
    bus2.vld = 1'b1;
    @(posedge clk);
    #1 bus2.vld = 1'b0;
    n = 0;
    while (sclk2 !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (sclk2 !== 1'b1) begin
      failures++;
      $display("FAIL reset_reach_shift_hi sclk=%b expected 1 within 50 cycles", sclk2);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sclk2, rclk2, dio2} !== 3'b000) begin
      failures++;
      $display("FAIL reset_async got sclk,rclk,dio=%b expected 000", {sclk2, rclk2, dio2});
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus2.rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdy_after_release got %b expected 1", bus2.rdy);
    end
    repeat (80) @(posedge clk);
    #1;
    checks++;
    if (rclk2_cnt !== 0) begin
      failures++;
      $display("FAIL reset_no_latch rclk rises=%0d expected 0", rclk2_cnt);
    end
  endtask

  task automatic test_single_frame();
    int lat, rhi;
    logic d_at, d_after;
    clear_mon();
    run_frame2(16'hA501, lat, rhi, d_at, d_after);
    checks++;
    if (lat !== 66) begin
      failures++;
      $display("FAIL single_latency got %0d expected 66", lat);
    end
    checks++;
    if (frames2.size() != 1 || frames2[0] !== 16'b1010_0101_0000_0001) begin
      failures++;
      $display("FAIL single_bits got n=%0d word=%h expected 1 frame a501", frames2.size(),
               (frames2.size() > 0) ? frames2[0] : 16'hxxxx);
    end
    checks++;
    if (sclk2_cnt !== 16 || rclk2_cnt !== 1) begin
      failures++;
      $display("FAIL single_edges got sclk=%0d rclk=%0d expected 16/1", sclk2_cnt, rclk2_cnt);
    end
    checks++;
    if (rhi !== 2) begin
      failures++;
      $display("FAIL single_rclk_width got %0d expected 2", rhi);
    end
    checks++;
    if ({d_at, d_after} !== 2'b10) begin
      failures++;
      $display("FAIL single_done_pulse got %b expected 10", {d_at, d_after});
    end
  endtask

  task automatic test_back_to_back();
    int dones, gap;
    clear_mon();
    dones = 0; gap = 0;
    @(negedge clk);
    bus2.dat = 16'h0301;
    bus2.vld = 1'b1;
    @(posedge clk);
    #1 bus2.dat = 16'h9F02;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (bus2.done === 1'b1) dones++;
      if (dones == 1 && bus2.rdy === 1'b1) gap++;
      if (dones == 1 && bus2.rdy === 1'b0) bus2.vld = 1'b0;
      if (dones == 2) break;
    end
    bus2.vld = 1'b0;
    checks++;
    if (dones !== 2 || gap !== 1) begin
      failures++;
      $display("FAIL b2b_handshake got done pulses=%0d idle gap=%0d expected 2/1", dones, gap);
    end
    checks++;
    if (sclk2_cnt !== 32 || rclk2_cnt !== 2) begin
      failures++;
      $display("FAIL b2b_edges got sclk=%0d rclk=%0d expected 32/2", sclk2_cnt, rclk2_cnt);
    end
    checks++;
    if (frames2.size() != 2 || frames2[0] !== 16'h0301 || frames2[1] !== 16'h9F02) begin
      failures++;
      $display("FAIL b2b_frames got n=%0d first=%h second=%h expected 0301 9f02", frames2.size(),
               (frames2.size() > 0) ? frames2[0] : 16'hxxxx,
               (frames2.size() > 1) ? frames2[1] : 16'hxxxx);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, busy_rdy;
    clear_mon();
    lat = -1; busy_rdy = 0;
    @(negedge clk);
    bus2.dat = 16'h5A3C;
    bus2.vld = 1'b1;
    @(posedge clk);
    #1 bus2.vld = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        bus2.dat = 16'hFFFF;
        bus2.vld = 1'b1;
      end else if (i == 2) begin
        bus2.vld = 1'b0;
      end
      if (bus2.rdy) begin
        lat = i;
        break;
      end
      busy_rdy++;
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (lat !== 66 || busy_rdy !== 65) begin
      failures++;
      $display("FAIL busy_rdy got latency=%0d busy cycles=%0d expected 66/65", lat, busy_rdy);
    end
    checks++;
    if (sclk2_cnt !== 16 || rclk2_cnt !== 1 || frames2.size() != 1 || frames2[0] !== 16'h5A3C) begin
      failures++;
      $display("FAIL busy_frame got sclk=%0d rclk=%0d word=%h expected 16/1/5a3c", sclk2_cnt,
               rclk2_cnt, (frames2.size() > 0) ? frames2[0] : 16'hxxxx);
    end
  endtask

  task automatic test_clk_div1();
    int lat;
    logic dio_low;
    clear_mon();
    lat = -1; dio_low = 1'b0;
    @(negedge clk);
    bus1.dat = 16'hFFFF;
    bus1.vld = 1'b1;
    @(posedge clk);
    #1 bus1.vld = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (bus1.rdy) begin
        lat = i;
        break;
      end
      if (sclk1 === 1'b1 && dio1 !== 1'b1) dio_low = 1'b1;
    end
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL div1_latency got %0d expected 33", lat);
    end
    checks++;
    if (per_min1 != 20 || per_max1 != 20 || sclk1_cnt !== 16 || rclk1_cnt !== 1) begin
      failures++;
      $display("FAIL div1_sclk got period %0t..%0t rises=%0d rclk=%0d expected 20/16/1",
               per_min1, per_max1, sclk1_cnt, rclk1_cnt);
    end
    checks++;
    if (bits1 !== 16'hFFFF || dio_low !== 1'b0) begin
      failures++;
      $display("FAIL div1_dio got bits=%h dip=%b expected ffff 0", bits1, dio_low);
    end
  endtask

  task automatic test_active_low();
    int lat, rhi;
    logic d_at, d_after;
    logic [15:0] exp_word;
`ifdef LED7SEG_ACTIVE_LOW_EN
    exp_word = 16'b1111_0000_1000_0000;
`else
    exp_word = 16'b0000_1111_1000_0000;
`endif
    clear_mon();
    run_frame2(16'h0F80, lat, rhi, d_at, d_after);
    checks++;
    if (frames2.size() != 1 || frames2[0] !== exp_word || lat !== 66) begin
      failures++;
      $display("FAIL polarity_bits got word=%h latency=%0d expected %h/66",
               (frames2.size() > 0) ? frames2[0] : 16'hxxxx, lat, exp_word);
    end
  endtask

  initial begin
    bus2.dat = '0; bus2.vld = 1'b0;
    bus1.dat = '0; bus1.vld = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_ignore();
    test_clk_div1();
    test_active_low();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
